// File: rtl/dm_byteen_ram_if.sv
// Request/response/trace bundle between the M-stage data port and dm_byteen_ram.
interface dm_byteen_ram_if #(
    parameter int unsigned BYTES = 4
);
    localparam int unsigned DW = 8 * BYTES;

    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_addr;
    logic [BYTES-1:0] req_byteen;
    logic [DW-1:0]    req_wdata;
    logic [31:0]      req_pc;

    logic             rsp_valid;
    logic [DW-1:0]    rsp_rdata;
    logic             rsp_err;

    logic             clr_busy;

    logic             wr_valid;
    logic [31:0]      wr_pc;
    logic [31:0]      wr_addr;
    logic [DW-1:0]    wr_data;

    modport master (
        output req_valid, req_addr, req_byteen, req_wdata, req_pc,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, clr_busy,
        input  wr_valid, wr_pc, wr_addr, wr_data
    );

    modport slave (
        input  req_valid, req_addr, req_byteen, req_wdata, req_pc,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, clr_busy,
        output wr_valid, wr_pc, wr_addr, wr_data
    );
endinterface

// File: rtl/dm_byteen_ram.sv
// Data-memory slave: byte-enable merged writes, fixed-latency in-order responses,
// range checking, post-reset clear sequencer and a registered write-trace port.
// LATENCY must lie in 1..4.
module dm_byteen_ram #(
    parameter int unsigned ADDR_W         = 12,
    parameter int unsigned BYTES          = 4,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned LATENCY        = 1,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input logic           clk,
    input logic           reset,
    dm_byteen_ram_if.slave bus
);
    localparam int unsigned DW         = 8 * BYTES;
    localparam int unsigned DEPTH      = 1 << ADDR_W;
    localparam int unsigned OFF_W      = $clog2(BYTES);
    localparam logic [31:0] ALIGN_MASK = ~(32'(BYTES) - 32'd1);

    typedef enum logic [0:0] {StClear, StRun} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] clr_idx_q;
    logic              req_ready_q;
    logic              clr_busy_q;

    logic [DW-1:0]     mem_q [DEPTH];

    logic [31:0]       offs;
    logic [31:0]       idx_full;
    logic              in_range;
    logic [ADDR_W-1:0] word_idx;
    logic              is_write;
    logic              accept;
    logic              wr_commit;
    logic [DW-1:0]     old_word;
    logic [DW-1:0]     merged_word;
    logic [DW-1:0]     rsp_word;

    logic [LATENCY-1:0] rsp_vld_q;
    logic [LATENCY-1:0] rsp_err_q;
    logic [DW-1:0]      rsp_dat_q [LATENCY];

    logic               wr_valid_q;
    logic [31:0]        wr_pc_q;
    logic [31:0]        wr_addr_q;
    logic [DW-1:0]      wr_data_q;

    // Address decode, range check and byte-lane merge against the current word.
    always_comb begin
        offs     = bus.req_addr - BASE_ADDR;
        idx_full = offs >> OFF_W;
        // No wrap: below-base addresses are rejected before the subtraction matters.
        in_range = (bus.req_addr >= BASE_ADDR) && ((idx_full >> ADDR_W) == 32'd0);
        word_idx = idx_full[ADDR_W-1:0];
        is_write = |bus.req_byteen;
        accept   = bus.req_valid && req_ready_q;
        wr_commit = accept && in_range && is_write;
        old_word = mem_q[word_idx];
        merged_word = old_word;
        for (int i = 0; i < int'(BYTES); i++) begin
            if (bus.req_byteen[i]) begin
                merged_word[8*i +: 8] = bus.req_wdata[8*i +: 8];
            end
        end
        if (!in_range) begin
            rsp_word = '0;
        end else if (is_write) begin
            rsp_word = merged_word;
        end else begin
            rsp_word = old_word;
        end
    end

    // Clear/run sequencer; req_ready and clr_busy are registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= CLEAR_ON_RESET ? StClear : StRun;
            clr_idx_q   <= '0;
            clr_busy_q  <= CLEAR_ON_RESET;
            req_ready_q <= 1'b0;
        end else begin
            unique case (state_q)
                StClear: begin
                    if (clr_idx_q == '1) begin
                        state_q     <= StRun;
                        clr_busy_q  <= 1'b0;
                        req_ready_q <= 1'b1;
                    end else begin
                        clr_idx_q <= clr_idx_q + 1'b1;
                    end
                end
                StRun: begin
                    clr_busy_q  <= 1'b0;
                    req_ready_q <= 1'b1;
                end
                default: state_q <= StRun;
            endcase
        end
    end

    // Storage array: zero fill while clearing, merged write on a committed request.
    // Not reset, so contents survive a reset when the clear is disabled.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == StClear) begin
                mem_q[clr_idx_q] <= '0;
            end else if (wr_commit) begin
                mem_q[word_idx] <= merged_word;
            end
        end
    end

    // Response delay line: stage 0 loads at accept, output taken from the last stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_vld_q <= '0;
            rsp_err_q <= '0;
            for (int i = 0; i < int'(LATENCY); i++) begin
                rsp_dat_q[i] <= '0;
            end
        end else begin
            rsp_vld_q[0] <= accept;
            rsp_err_q[0] <= accept && !in_range;
            rsp_dat_q[0] <= accept ? rsp_word : '0;
            for (int i = 1; i < int'(LATENCY); i++) begin
                rsp_vld_q[i] <= rsp_vld_q[i-1];
                rsp_err_q[i] <= rsp_err_q[i-1];
                rsp_dat_q[i] <= rsp_dat_q[i-1];
            end
        end
    end

    // Write-trace register, one cycle after each committed in-range write.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_valid_q <= 1'b0;
            wr_pc_q    <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            wr_valid_q <= wr_commit;
            wr_pc_q    <= wr_commit ? bus.req_pc : '0;
            wr_addr_q  <= wr_commit ? (bus.req_addr & ALIGN_MASK) : '0;
            wr_data_q  <= wr_commit ? merged_word : '0;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.clr_busy  = clr_busy_q;
    assign bus.rsp_valid = rsp_vld_q[LATENCY-1];
    assign bus.rsp_err   = rsp_err_q[LATENCY-1];
    assign bus.rsp_rdata = rsp_dat_q[LATENCY-1];
    assign bus.wr_valid  = wr_valid_q;
    assign bus.wr_pc     = wr_pc_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;

endmodule

// File: tb/tb_dm_byteen_ram.sv
// Directed bench for dm_byteen_ram: four small instances cover clear timing,
// merge writes, pipelining, range errors, base offset and reset behaviour.
module tb_dm_byteen_ram;
    logic clk;
    logic rst;
    logic rst2;

    int n_tests = 0;
    int n_fail  = 0;

    dm_byteen_ram_if #(.BYTES(4)) if0 ();
    dm_byteen_ram_if #(.BYTES(4)) if1 ();
    dm_byteen_ram_if #(.BYTES(4)) if2 ();
    dm_byteen_ram_if #(.BYTES(4)) if3 ();

    dm_byteen_ram #(.ADDR_W(4), .BYTES(4), .BASE_ADDR(32'h0), .LATENCY(2), .CLEAR_ON_RESET(1'b1))
        u0 (.clk(clk), .reset(rst), .bus(if0));
    dm_byteen_ram #(.ADDR_W(4), .BYTES(4), .BASE_ADDR(32'h0), .LATENCY(3), .CLEAR_ON_RESET(1'b1))
        u1 (.clk(clk), .reset(rst), .bus(if1));
    dm_byteen_ram #(.ADDR_W(4), .BYTES(4), .BASE_ADDR(32'h0), .LATENCY(4), .CLEAR_ON_RESET(1'b1))
        u2 (.clk(clk), .reset(rst2), .bus(if2));
    dm_byteen_ram #(.ADDR_W(4), .BYTES(4), .BASE_ADDR(32'h100), .LATENCY(1), .CLEAR_ON_RESET(1'b0))
        u3 (.clk(clk), .reset(rst), .bus(if3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        logic        wr;
    } vec_t;

    vec_t v3 [8];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        if0.req_valid = 1'b0; if0.req_addr = '0; if0.req_byteen = '0; if0.req_wdata = '0; if0.req_pc = '0;
        if1.req_valid = 1'b0; if1.req_addr = '0; if1.req_byteen = '0; if1.req_wdata = '0; if1.req_pc = '0;
        if2.req_valid = 1'b0; if2.req_addr = '0; if2.req_byteen = '0; if2.req_wdata = '0; if2.req_pc = '0;
        if3.req_valid = 1'b0; if3.req_addr = '0; if3.req_byteen = '0; if3.req_wdata = '0; if3.req_pc = '0;
    endtask

    task automatic drive0(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d,
                          input logic [31:0] pc);
        if0.req_valid = 1'b1; if0.req_addr = a; if0.req_byteen = be; if0.req_wdata = d;
        if0.req_pc = pc;
    endtask

    initial begin
        int n;
        int busy_cnt;
        int seen;
        int rk [$];
        logic [31:0] rd [$];
        logic [31:0] exp1 [4];

        v3[0] = '{32'h0000_00FC, 4'h0, 32'h0,          32'h0,          1'b1, 1'b0};
        v3[1] = '{32'h0000_0104, 4'hF, 32'h1357_2468, 32'h1357_2468, 1'b0, 1'b1};
        v3[2] = '{32'h0000_0104, 4'h0, 32'h0,          32'h1357_2468, 1'b0, 1'b0};
        v3[3] = '{32'h0000_013C, 4'hF, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 1'b1};
        v3[4] = '{32'h0000_0140, 4'hF, 32'hFFFF_FFFF, 32'h0,          1'b1, 1'b0};
        v3[5] = '{32'h0000_013C, 4'h0, 32'h0,          32'h0BAD_F00D, 1'b0, 1'b0};
        v3[6] = '{32'h0000_0105, 4'h2, 32'h0000_CD00, 32'h1357_CD68, 1'b0, 1'b1};
        v3[7] = '{32'h0000_0104, 4'h0, 32'h0,          32'h1357_CD68, 1'b0, 1'b0};
        exp1[0] = 32'h1111_1111; exp1[1] = 32'h1111_1111;
        exp1[2] = 32'h1111_1122; exp1[3] = 32'h1111_1122;

        idle_all();
        rst = 1'b1;
        rst2 = 1'b1;
        tick();
        tick();

        // Reset state.
        check_eq("rst_ready", 64'(if0.req_ready), 64'd0);
        check_eq("rst_busy", 64'(if0.clr_busy), 64'd1);
        check_eq("rst_rsp", 64'({if0.rsp_valid, if0.rsp_err, if0.rsp_rdata}), 64'd0);
        check_eq("rst_wr", 64'({if0.wr_valid, if0.wr_addr}), 64'd0);
        check_eq("rst_busy_noclr", 64'(if3.clr_busy), 64'd0);
        check_eq("rst_ready_noclr", 64'(if3.req_ready), 64'd0);

        // Clear timing: busy for 16 cycles, ready on cycle 17.
        rst = 1'b0;
        rst2 = 1'b0;
        n = 0;
        busy_cnt = 0;
        while (!if0.req_ready && n < 40) begin
            if (if0.clr_busy) busy_cnt++;
            tick();
            n++;
            if (n == 1) check_eq("noclr_ready_c2", 64'(if3.req_ready), 64'd1);
        end
        check_eq("clr_edges", 64'(n), 64'd16);
        check_eq("clr_busy_cycles", 64'(busy_cnt), 64'd16);
        check_eq("clr_busy_done", 64'(if0.clr_busy), 64'd0);
        check_eq("clr_ready_u2", 64'(if2.req_ready), 64'd1);

        // u0, LATENCY=2: write, read, byte merges, out-of-range.
        drive0(32'h10, 4'hF, 32'hDEAD_BEEF, 32'h0040_0100);
        tick();
        check_eq("w10_wr_valid", 64'(if0.wr_valid), 64'd1);
        check_eq("w10_wr_addr", 64'(if0.wr_addr), 64'h10);
        check_eq("w10_wr_data", 64'(if0.wr_data), 64'hDEAD_BEEF);
        check_eq("w10_wr_pc", 64'(if0.wr_pc), 64'h0040_0100);
        check_eq("w10_rsp_early", 64'(if0.rsp_valid), 64'd0);
        drive0(32'h10, 4'h0, 32'h0, 32'h0040_0104);
        tick();
        check_eq("w10_rsp", 64'({if0.rsp_valid, if0.rsp_err, if0.rsp_rdata}), {31'd0, 1'b1, 1'b0, 32'hDEAD_BEEF});
        check_eq("r10_no_trace", 64'(if0.wr_valid), 64'd0);
        drive0(32'h12, 4'h4, 32'h00AA_0000, 32'h0040_0108);
        tick();
        check_eq("r10_rsp", 64'({if0.rsp_valid, if0.rsp_rdata}), {31'd0, 1'b1, 32'hDEAD_BEEF});
        check_eq("m1_wr_data", 64'(if0.wr_data), 64'hDEAA_BEEF);
        check_eq("m1_wr_addr", 64'(if0.wr_addr), 64'h10);
        drive0(32'h10, 4'h3, 32'h0000_1234, 32'h0040_010C);
        tick();
        check_eq("m1_rsp", 64'({if0.rsp_valid, if0.rsp_rdata}), {31'd0, 1'b1, 32'hDEAA_BEEF});
        check_eq("m2_wr_data", 64'(if0.wr_data), 64'hDEAA_1234);
        drive0(32'h40, 4'hF, 32'hCAFE_F00D, 32'h0040_0110);
        tick();
        check_eq("m2_rsp", 64'({if0.rsp_valid, if0.rsp_rdata}), {31'd0, 1'b1, 32'hDEAA_1234});
        check_eq("oor_no_trace", 64'(if0.wr_valid), 64'd0);
        drive0(32'h00, 4'h0, 32'h0, 32'h0040_0114);
        tick();
        if0.req_valid = 1'b0;
        check_eq("oor_rsp", 64'({if0.rsp_valid, if0.rsp_err, if0.rsp_rdata}), {31'd0, 1'b1, 1'b1, 32'h0});
        check_eq("oor_trace_still0", 64'(if0.wr_valid), 64'd0);
        tick();
        check_eq("r00_rsp", 64'({if0.rsp_valid, if0.rsp_err, if0.rsp_rdata}), {31'd0, 1'b1, 1'b0, 32'h0});
        tick();
        check_eq("idle_rsp_zero", 64'({if0.rsp_valid, if0.rsp_err, if0.rsp_rdata}), 64'd0);

        // u1, LATENCY=3: four back-to-back requests on the same word.
        for (int k = 0; k < 10; k++) begin
            if1.req_valid = (k < 4);
            if1.req_addr = 32'h20;
            case (k)
                0: begin if1.req_byteen = 4'hF; if1.req_wdata = 32'h1111_1111; end
                2: begin if1.req_byteen = 4'h1; if1.req_wdata = 32'h0000_0022; end
                default: begin if1.req_byteen = 4'h0; if1.req_wdata = 32'h0; end
            endcase
            tick();
            if (if1.rsp_valid) begin
                rk.push_back(k);
                rd.push_back(if1.rsp_rdata);
            end
        end
        if1.req_valid = 1'b0;
        check_eq("b2b_count", 64'(rk.size()), 64'd4);
        for (int i = 0; i < 4 && i < rk.size(); i++) begin
            check_eq($sformatf("b2b_slot%0d", i), 64'(rk[i]), 64'(i + 2));
            check_eq($sformatf("b2b_data%0d", i), 64'(rd[i]), 64'(exp1[i]));
        end

        // u2, LATENCY=4: latency, then reset with two reads in flight.
        if2.req_valid = 1'b1; if2.req_addr = 32'h08; if2.req_byteen = 4'hF;
        if2.req_wdata = 32'h5A5A_5A5A;
        tick();
        if2.req_valid = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            tick();
            if (j == 2) check_eq("lat4_early", 64'(if2.rsp_valid), 64'd0);
            if (j == 3) check_eq("lat4_rsp", 64'({if2.rsp_valid, if2.rsp_rdata}), {31'd0, 1'b1, 32'h5A5A_5A5A});
        end
        if2.req_valid = 1'b1; if2.req_byteen = 4'h0; if2.req_wdata = '0;
        tick();
        tick();
        if2.req_valid = 1'b0;
        tick();
        rst2 = 1'b1;
        tick();
        rst2 = 1'b0;
        check_eq("mid_rst_busy", 64'(if2.clr_busy), 64'd1);
        check_eq("mid_rst_ready", 64'(if2.req_ready), 64'd0);
        check_eq("mid_rst_rsp", 64'(if2.rsp_valid), 64'd0);
        n = 0;
        seen = 0;
        while (!if2.req_ready && n < 40) begin
            tick();
            n++;
            if (if2.rsp_valid) seen++;
        end
        check_eq("mid_rst_no_rsp", 64'(seen), 64'd0);
        check_eq("mid_rst_clr_edges", 64'(n), 64'd16);
        if2.req_valid = 1'b1; if2.req_addr = 32'h08; if2.req_byteen = 4'h0;
        tick();
        if2.req_valid = 1'b0;
        tick(); tick(); tick();
        check_eq("mid_rst_rezero", 64'({if2.rsp_valid, if2.rsp_rdata}), {31'd0, 1'b1, 32'h0});

        // u3, LATENCY=1, BASE_ADDR=0x100, no clear: table of vectors.
        for (int k = 0; k < 8; k++) begin
            if3.req_valid = 1'b1; if3.req_addr = v3[k].addr; if3.req_byteen = v3[k].be;
            if3.req_wdata = v3[k].wdata; if3.req_pc = 32'h0040_0200 + 32'(4 * k);
            tick();
            check_eq($sformatf("v3_%0d_rsp", k),
                     64'({if3.rsp_valid, if3.rsp_err, if3.rsp_rdata}),
                     {31'd0, 1'b1, v3[k].err, v3[k].rdata});
            check_eq($sformatf("v3_%0d_wrv", k), 64'(if3.wr_valid), 64'(v3[k].wr));
            if (v3[k].wr) begin
                check_eq($sformatf("v3_%0d_wra", k), 64'(if3.wr_addr), 64'(v3[k].addr & 32'hFFFF_FFFC));
            end
        end

        // Request presented during reset is not accepted; contents retained.
        if3.req_valid = 1'b1; if3.req_addr = 32'h104; if3.req_byteen = 4'hF;
        if3.req_wdata = 32'hFFFF_FFFF;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if3.req_valid = 1'b0;
        check_eq("rst_req_no_trace", 64'(if3.wr_valid), 64'd0);
        check_eq("rst_req_no_rsp", 64'(if3.rsp_valid), 64'd0);
        n = 0;
        while (!if3.req_ready && n < 10) begin
            tick();
            n++;
        end
        check_eq("retain_ready", 64'(n), 64'd1);
        if3.req_valid = 1'b1; if3.req_addr = 32'h104; if3.req_byteen = 4'h0;
        tick();
        if3.req_valid = 1'b0;
        check_eq("retain_data", 64'({if3.rsp_valid, if3.rsp_rdata}), {31'd0, 1'b1, 32'h1357_CD68});
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dm_byteen_ram.md
Name: dm_byteen_ram

Overview:
Parametrised, synthesizable data-memory slave for the pipelined MIPS CPU, sitting on the M-stage data port. It replaces the behavioural data array with a real block that has these features:
- byte-enable merged writes
- a valid/ready request handshake
- configurable read latency
- address range checking
- a hardware clear sequencer run after reset
- a registered write-trace port for the bench to log

Parameters:
ADDR_W, 12, word-address bits; depth DEPTH = 2**ADDR_W words
BYTES, 4, bytes per word; data width DW = 8*BYTES; byteen width = BYTES
BASE_ADDR, 32'h0000_0000, byte address of word 0
LATENCY, 1, request-accept to rsp_valid in cycles; legal range 1..4
CLEAR_ON_RESET, 1, 1 = zero all words after reset; 0 = skip the clear

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  block can accept this cycle
req_addr  in  32  byte address; low log2(BYTES) bits ignored
req_byteen  in  BYTES  per-byte write enable; all-zero = read
req_wdata  in  DW  write data, byte lanes aligned to word
req_pc  in  32  PC of issuing instruction (trace only)
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  DW  read: stored word; write: merged word written
rsp_err  out  1  request was out of range
clr_busy  out  1  clear sequencer active
wr_valid  out  1  trace: a write committed last cycle
wr_pc  out  32  trace: req_pc of that write
wr_addr  out  32  trace: aligned byte address of that write
wr_data  out  DW  trace: full merged word written

Behaviour:
- Reset (sync, clk): all outputs 0, including req_ready, rsp_*, wr_* and the pipeline; clr_busy=1 if CLEAR_ON_RESET else 0.
- FSM states: CLEAR, RUN.
  - reset -> CLEAR if CLEAR_ON_RESET, else RUN.
  - CLEAR: index counter 0..DEPTH-1 writes 0 to one word per cycle; clr_busy=1, req_ready=0. After the write to DEPTH-1: -> RUN, clr_busy=0.
  - Clear takes exactly DEPTH cycles; req_ready is high on cycle DEPTH+1 after reset deasserts.
  - RUN: req_ready=1 continuously; no internal backpressure.
- Accept = req_valid && req_ready. At most one request per cycle; fully pipelined.
- Word index = (req_addr - BASE_ADDR) >> log2(BYTES). In range iff req_addr >= BASE_ADDR and index < DEPTH, using 32-bit unsigned compare with no wrap.
- Write (byteen != 0, in range): committed at the accept edge. For each set byteen[i], byte i = req_wdata byte i; other bytes keep their old value.
- Read (byteen == 0): returns the word as stored at the accept edge.
- Ordering: a request accepted on the cycle after a write to the same word sees the new data; no hazard window.
- Response timing: every accepted request gets exactly one rsp_valid pulse LATENCY cycles after accept. Responses come in accept order; there is no response-side backpressure.
- rsp_rdata: for a read, the old word; for a write, the merged word.
- Out of range: no array write and no trace. The response still occurs with rsp_err=1 and rsp_rdata=0.
- rsp_rdata and rsp_err are 0 whenever rsp_valid=0.
- Trace port: registered, one cycle after each committed in-range write. wr_valid=1 with wr_addr = req_addr & ~(BYTES-1), wr_data = merged word, wr_pc = req_pc. wr_* is 0 otherwise.
- Reset mid-operation:
  - In-flight responses are discarded; no rsp_valid after the reset edge.
  - A pending trace pulse is dropped.
  - The clear restarts from index 0 and array contents are re-zeroed.
  - With CLEAR_ON_RESET=0, array contents are retained.
- Reset asserted in the same cycle as req_valid: the request is not accepted.

Test Plan:
- Clear timing (ADDR_W=4, CLEAR_ON_RESET=1): release reset -> clr_busy high 16 cycles; req_ready rises on cycle 17; a read of 0x3C returns 0.
- Full write/read (LATENCY=2): write 0x10, byteen=F, data 0xDEADBEEF -> wr_valid next cycle with wr_addr=0x10, wr_data=DEADBEEF; rsp_valid 2 cycles after accept. Read 0x10 on the next cycle -> rsp_rdata=DEADBEEF.
- Byte merge: word 0x10=DEADBEEF, write 0x12 byteen=0100 data 0x00AA0000 -> wr_data=DEAABEEF. Then byteen=0011 data 0x00001234 -> DEAA1234.
- Back-to-back pipeline (LATENCY=3): W(0x20,F,0x11111111), R(0x20), W(0x20,1,0x22), R(0x20) on four consecutive cycles -> four in-order responses on consecutive cycles: 11111111, 11111111, 11111122, 11111122.
- Out of range (ADDR_W=4, BASE_ADDR=0): write 0x40 -> rsp_err=1, rdata=0, wr_valid stays 0. Read 0x00 still returns its prior value. BASE_ADDR=0x100 with read 0xFC -> rsp_err=1.
- Reset mid-pipeline (LATENCY=4): accept two reads, assert reset 1 cycle later -> no rsp_valid ever appears for those reads; clr_busy=1 and the clear restarts; memory reads 0 afterwards.
